udp_rx_mport: RTL and testbench

Parametrised successor to the board's single-stream UDP receiver. Parses GMII receive bytes (preamble, Ethernet II header, IPv4 header with options, UDP header) and delivers payload for a range of destination ports. Payload is packed into a configurable-width word. Sits between the GMII RX interface and the per-port payload consumers in the Ethernet RX path.

---
 rtl/udp_rx_mport.sv | 225 ++++++++++++++++++++++
 tb/tb_udp_rx_mport.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_mport.sv
// udp_rx_mport: GMII receive parser for Ethernet II / IPv4 / UDP frames.
// Delivers the payload of frames addressed to BOARD_MAC (or broadcast),
// BOARD_IP and UDP ports PORT_BASE..PORT_BASE+NUM_PORTS-1, packed MSB-first
// into DATA_W-bit words.
// Optional build macro: UDP_RX_MPORT_CSUM_EN enables IPv4 header checksum
// verification. When it is left undefined the checksum is not inspected.
module udp_rx_mport #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] PORT_BASE = 16'd1234,
  parameter int          NUM_PORTS = 4,
  parameter int          DATA_W    = 8,
  localparam int         PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gmii_rx_dv,
  input  logic [7:0]        gmii_rxd,
  output logic              rec_en,
  output logic [DATA_W-1:0] rec_data,
  output logic              rec_pkt_done,
  output logic [15:0]       rec_byte_num,
  output logic [PW-1:0]     rec_port_idx,
  output logic              rec_err
);

  localparam int          BPW      = DATA_W / 8;
  localparam logic [16:0] PORT_END = 17'(PORT_BASE) + 17'(NUM_PORTS);

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    PREAMBLE = 7'b0000010,
    ETH_HEAD = 7'b0000100,
    IP_HEAD  = 7'b0001000,
    UDP_HEAD = 7'b0010000,
    RX_DATA  = 7'b0100000,
    RX_END   = 7'b1000000
  } state_t;

  state_t            state;
  logic [5:0]        cnt;        // byte index in header, byte index in word in RX_DATA
  logic [3:0]        ihl;
  logic              uc_ok, bc_ok, type_ok;
  logic [7:0]        hi_byte;    // upper byte of the 16-bit field being assembled
  logic [15:0]       dport, ulen, pay_len, data_cnt;
  logic [DATA_W-1:0] sh;         // bytes of the word collected so far, right-aligned

  logic [7:0]        mac_byte, ip_byte;
  logic [5:0]        hlen_last, pad_bytes;
  logic [DATA_W-1:0] nxt_word, aligned;
  logic [15:0]       pay_calc;
  logic              dport_ok, csum_ok;

`ifdef UDP_RX_MPORT_CSUM_EN
  logic [15:0] csum, sum_nxt;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // running ones'-complement sum including the word completed by this byte
  always_comb begin
    sum_nxt = oc_add(csum, {hi_byte, gmii_rxd});
    csum_ok = (sum_nxt == 16'hFFFF);
  end
`else
  assign csum_ok = 1'b1;
`endif

  // header field references and payload word assembly
  always_comb begin
    mac_byte  = 8'(BOARD_MAC >> {3'd5 - cnt[2:0], 3'b000});
    ip_byte   = 8'(BOARD_IP >> {2'd3 - cnt[1:0], 3'b000});
    hlen_last = {ihl, 2'b00} - 6'd1;
    nxt_word  = DATA_W'({sh, gmii_rxd});
    pad_bytes = 6'(BPW - 1) - cnt;
    aligned   = nxt_word << {pad_bytes, 3'b000};
    pay_calc  = ulen - 16'd8;
    dport_ok  = ({1'b0, dport} >= {1'b0, PORT_BASE}) && ({1'b0, dport} < PORT_END);
  end

  // receive state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ihl          <= '0;
      uc_ok        <= 1'b0;
      bc_ok        <= 1'b0;
      type_ok      <= 1'b0;
      hi_byte      <= '0;
      dport        <= '0;
      ulen         <= '0;
      pay_len      <= '0;
      data_cnt     <= '0;
      sh           <= '0;
      rec_en       <= 1'b0;
      rec_data     <= '0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= '0;
      rec_port_idx <= '0;
      rec_err      <= 1'b0;
`ifdef UDP_RX_MPORT_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      rec_en       <= 1'b0;
      rec_pkt_done <= 1'b0;
      rec_err      <= 1'b0;
      case (state)
        IDLE: if (gmii_rx_dv && gmii_rxd == 8'h55) begin
          state <= PREAMBLE;
          cnt   <= '0;
        end
        PREAMBLE: begin
          if (gmii_rx_dv && gmii_rxd == 8'h55 && cnt < 6'd6) cnt <= cnt + 6'd1;
          else if (gmii_rx_dv && gmii_rxd == 8'hD5 && cnt == 6'd6) begin
            state   <= ETH_HEAD;
            cnt     <= '0;
            uc_ok   <= 1'b1;
            bc_ok   <= 1'b1;
            type_ok <= 1'b1;
          end else state <= RX_END;
        end
        ETH_HEAD: begin
          if (!gmii_rx_dv) state <= RX_END;
          else begin
            cnt <= cnt + 6'd1;
            if (cnt < 6'd6) begin
              if (gmii_rxd != mac_byte) uc_ok <= 1'b0;
              if (gmii_rxd != 8'hFF)    bc_ok <= 1'b0;
            end
            if (cnt == 6'd12 && gmii_rxd != 8'h08) type_ok <= 1'b0;
            if (cnt == 6'd13) begin
              cnt <= '0;
`ifdef UDP_RX_MPORT_CSUM_EN
              csum <= '0;
`endif
              if ((uc_ok || bc_ok) && type_ok && gmii_rxd == 8'h00) state <= IP_HEAD;
              else state <= RX_END;
            end
          end
        end
        IP_HEAD: begin
          if (!gmii_rx_dv) begin
            rec_err <= 1'b1;
            state   <= RX_END;
          end else begin
            cnt <= cnt + 6'd1;
`ifdef UDP_RX_MPORT_CSUM_EN
            if (!cnt[0]) hi_byte <= gmii_rxd;
            else         csum    <= sum_nxt;
`endif
            if (cnt == 6'd0) begin
              ihl <= gmii_rxd[3:0];
              if (gmii_rxd[3:0] < 4'd5) state <= RX_END;
            end else if (cnt == 6'd9 && gmii_rxd != 8'd17) state <= RX_END;
            else if (cnt >= 6'd16 && cnt <= 6'd19 && gmii_rxd != ip_byte) state <= RX_END;
            else if (cnt == hlen_last) begin
              cnt   <= '0;
              state <= csum_ok ? UDP_HEAD : RX_END;
            end
          end
        end
        UDP_HEAD: begin
          if (!gmii_rx_dv) begin
            rec_err <= 1'b1;
            state   <= RX_END;
          end else begin
            cnt <= cnt + 6'd1;
            case (cnt)
              6'd2, 6'd4: hi_byte <= gmii_rxd;
              6'd3:       dport   <= {hi_byte, gmii_rxd};
              6'd5:       ulen    <= {hi_byte, gmii_rxd};
              6'd7: begin
                cnt      <= '0;
                sh       <= '0;
                data_cnt <= '0;
                if (dport_ok && ulen >= 16'd8) begin
                  rec_port_idx <= PW'(dport - PORT_BASE);
                  pay_len      <= pay_calc;
                  if (pay_calc == 16'd0) begin
                    rec_pkt_done <= 1'b1;
                    rec_byte_num <= '0;
                    state        <= RX_END;
                  end else state <= RX_DATA;
                end else state <= RX_END;
              end
              default: ;
            endcase
          end
        end
        RX_DATA: begin
          if (!gmii_rx_dv) begin
            rec_err <= 1'b1;
            state   <= RX_END;
          end else begin
            data_cnt <= data_cnt + 16'd1;
            if (data_cnt == pay_len - 16'd1) begin
              // final byte: flush the partial word left-aligned
              rec_en       <= 1'b1;
              rec_data     <= aligned;
              rec_pkt_done <= 1'b1;
              rec_byte_num <= pay_len;
              state        <= RX_END;
            end else if (cnt == 6'(BPW - 1)) begin
              rec_en   <= 1'b1;
              rec_data <= nxt_word;
              sh       <= '0;
              cnt      <= '0;
            end else begin
              sh  <= nxt_word;
              cnt <= cnt + 6'd1;
            end
          end
        end
        RX_END: if (!gmii_rx_dv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_mport.sv
// Randomized scoreboard bench for udp_rx_mport: one 8-bit and one 32-bit
// instance share the GMII input; each has its own expected-event queue.
module tb_udp_rx_mport;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IP  = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [15:0] PB  = 16'd1234;
  localparam int          NP  = 4;

  logic clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
  logic [7:0] rxd = 8'h00;
  always #4 clk = ~clk;

  logic        en8, done8, err8, en32, done32, err32;
  logic [7:0]  data8;
  logic [31:0] data32;
  logic [15:0] bn8, bn32;
  logic [1:0]  pi8, pi32;

  udp_rx_mport #(.BOARD_MAC(MAC), .BOARD_IP(IP), .PORT_BASE(PB), .NUM_PORTS(NP), .DATA_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .rec_en(en8), .rec_data(data8), .rec_pkt_done(done8), .rec_byte_num(bn8),
    .rec_port_idx(pi8), .rec_err(err8));

  udp_rx_mport #(.BOARD_MAC(MAC), .BOARD_IP(IP), .PORT_BASE(PB), .NUM_PORTS(NP), .DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .rec_en(en32), .rec_data(data32), .rec_pkt_done(done32), .rec_byte_num(bn32),
    .rec_port_idx(pi32), .rec_err(err32));

  typedef struct {
    bit          en;
    logic [31:0] data;
    bit          done;
    logic [15:0] bn;
    logic [1:0]  pi;
    bit          err;
  } ev_t;

  ev_t q8[$], q32[$];
  logic [7:0] pay[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input string tag, input ev_t e, input logic en, input logic [31:0] d,
                     input logic done, input logic [15:0] bn, input logic [1:0] pi, input logic err);
    chk({tag, "_en"}, en, e.en);
    if (e.en) chk({tag, "_data"}, d, e.data);
    chk({tag, "_done"}, done, e.done);
    if (e.done) chk({tag, "_byte_num"}, bn, e.bn);
    chk({tag, "_port_idx"}, pi, e.pi);
    chk({tag, "_err"}, err, e.err);
  endtask

  // monitors: every output event pops one expected event
  always @(negedge clk) if (rst_n && (en8 || done8 || err8)) begin : mon8
    ev_t e;
    if (q8.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL dw8_unexpected: got en=%0b done=%0b err=%0b want no event", en8, done8, err8);
    end else begin
      e = q8.pop_front();
      mon("dw8", e, en8, {24'h0, data8}, done8, bn8, pi8, err8);
    end
  end

  always @(negedge clk) if (rst_n && (en32 || done32 || err32)) begin : mon32
    ev_t e;
    if (q32.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL dw32_unexpected: got en=%0b done=%0b err=%0b want no event", en32, done32, err32);
    end else begin
      e = q32.pop_front();
      mon("dw32", e, en32, data32, done32, bn32, pi32, err32);
    end
  end

  // reference: what an accepted frame delivers for a given word size
  task automatic expect_words(input int bpw, input int plen, input int trunc, input logic [1:0] pi);
    ev_t e;
    int n, nw;
    n = (trunc >= 0) ? trunc : plen;
    nw = (trunc >= 0) ? n / bpw : (plen + bpw - 1) / bpw;
    for (int w = 0; w < nw; w++) begin
      e = '{en: 1'b1, data: 32'h0, done: 1'b0, bn: 16'h0, pi: pi, err: 1'b0};
      for (int j = 0; j < bpw; j++)
        e.data = (e.data << 8) | ((w * bpw + j < n) ? {24'h0, pay[w * bpw + j]} : 32'h0);
      if (trunc < 0 && w == nw - 1) begin e.done = 1'b1; e.bn = 16'(plen); end
      if (bpw == 1) q8.push_back(e); else q32.push_back(e);
    end
    e = '{en: 1'b0, data: 32'h0, done: 1'b0, bn: 16'h0, pi: pi, err: 1'b0};
    if (trunc >= 0) e.err = 1'b1;
    else if (plen == 0) e.done = 1'b1;
    if (trunc >= 0 || plen == 0) begin
      if (bpw == 1) q8.push_back(e); else q32.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [47:0] mac, input logic [15:0] et, input logic [3:0] ihl,
                            input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                            input logic [15:0] ulen, input int trunc, input bit badck);
    logic [7:0] fr[$];
    logic [7:0] hdr[60];
    logic [15:0] ck;
    int hl, sum, lim;
    hl = int'(ihl) * 4;
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(8'(mac >> (8 * (5 - i))));
    repeat (6) fr.push_back(8'($urandom));
    fr.push_back(et[15:8]); fr.push_back(et[7:0]);
    for (int i = 0; i < 60; i++) hdr[i] = 8'($urandom);
    hdr[0] = {4'h4, ihl}; hdr[9] = proto; hdr[10] = 8'h0; hdr[11] = 8'h0;
    for (int i = 0; i < 4; i++) hdr[16 + i] = 8'(dip >> (8 * (3 - i)));
    sum = 0;
    for (int i = 0; i + 1 < hl; i += 2) sum += int'({hdr[i], hdr[i + 1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    hdr[10] = ck[15:8]; hdr[11] = ck[7:0];
    if (badck) hdr[10] = hdr[10] ^ 8'h01;
    for (int i = 0; i < hl; i++) fr.push_back(hdr[i]);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
    fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    lim = fr.size() + trunc;
    foreach (pay[i]) fr.push_back(pay[i]);
    repeat ($urandom_range(4, 14)) fr.push_back(8'($urandom));   // padding + FCS
    if (trunc < 0) lim = fr.size();
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1; dv = 1'b1; rxd = fr[i];
    end
    @(posedge clk); #1; dv = 1'b0; rxd = 8'h00;
    repeat ($urandom_range(1, 6)) @(posedge clk);
  endtask

  initial begin
    logic [47:0] mac;
    logic [15:0] et, dport, ulen;
    logic [3:0]  ihl;
    logic [7:0]  proto;
    logic [31:0] dip;
    int kind, plen, trunc;
    bit badck, acc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en8", en8, 0);     chk("rst_data8", data8, 0);   chk("rst_done8", done8, 0);
    chk("rst_bn8", bn8, 0);     chk("rst_pi8", pi8, 0);       chk("rst_err8", err8, 0);
    chk("rst_en32", en32, 0);   chk("rst_data32", data32, 0); chk("rst_done32", done32, 0);
    chk("rst_bn32", bn32, 0);   chk("rst_pi32", pi32, 0);     chk("rst_err32", err32, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 70; i++) begin
      kind  = (i < 2) ? 0 : (i < 14) ? i - 2 : int'($urandom_range(0, 11));
      mac   = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : MAC;
      et    = 16'h0800;
      ihl   = 4'($urandom_range(5, 7));
      proto = 8'd17;
      dip   = IP;
      dport = PB + 16'($urandom_range(0, NP - 1));
      plen  = $urandom_range(1, 40);
      trunc = -1;
      badck = 1'b0;
      acc   = 1'b1;
      case (kind)
        1:  begin mac = mac ^ (48'h1 << $urandom_range(0, 47)); acc = 1'b0; end
        2:  begin et = 16'h86DD; acc = 1'b0; end
        3:  begin proto = 8'd6; acc = 1'b0; end
        4:  begin plen = 0; acc = 1'b0; end                       // ulen = 7
        5:  plen = 0;                                             // ulen = 8
        6:  begin dport = ($urandom_range(0, 1) == 1) ? PB + 16'(NP) : PB - 16'd1; acc = 1'b0; end
        7:  begin plen = $urandom_range(2, 40); trunc = $urandom_range(0, plen - 1); end
        8:  begin dip = dip ^ (32'h1 << $urandom_range(0, 31)); acc = 1'b0; end
        9:  begin
              badck = 1'b1;
`ifdef UDP_RX_MPORT_CSUM_EN
              acc = 1'b0;
`endif
            end
        10: ihl = 4'($urandom_range(8, 15));
        11: begin ihl = 4'($urandom_range(0, 4)); acc = 1'b0; end
        default: ;
      endcase
      if (i == 0) begin dport = PB + 16'd1; plen = 18; mac = MAC; end
      if (i == 1) plen = 6;
      if (i == 2) begin plen = 10; end
      if (i == 9) begin plen = 10; trunc = 5; end
      ulen = (kind == 4) ? 16'd7 : 16'(plen + 8);
      pay.delete();
      for (int j = 0; j < plen; j++)
        pay.push_back((i == 0) ? 8'(j) : (i == 1) ? 8'(8'hAA + 8'(17 * j)) : 8'($urandom));
      if (acc) begin
        expect_words(1, plen, trunc, 2'(dport - PB));
        expect_words(4, plen, trunc, 2'(dport - PB));
      end
      send_frame(mac, et, ihl, proto, dip, dport, ulen, trunc, badck);
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("dw8_pending_events", q8.size(), 0);
    chk("dw32_pending_events", q32.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
